matrix_bank: RTL

Parametrised next-generation matrix store for the matrix-calculator datapath. It holds up to SLOTS_PER_DIM matrices per (m,n) dimension pair in round-robin order and accepts elements as a row-major stream. It zero-pads a short input on request, commits a slot only once its write completes, and serves registered single-element reads plus per-dimension occupancy queries. It sits between the UART input FSM (writer) and the compute/display FSMs (readers).

---
 rtl/matrix_bank.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/matrix_bank.sv
// matrix_bank: round-robin matrix store for the matrix-calculator datapath.
// Elements arrive as a row-major stream. A slot becomes readable only once
// its write has committed. Reads are registered with single-cycle latency,
// and occupancy queries are combinational.
// Optional feature macro: MATRIX_BANK_AUTOPAD_EN. When it is defined, a short
// write ended by wr_finish is zero-padded and then committed. When it is
// undefined, such a write is aborted and wr_err pulses.
module matrix_bank #(
  parameter int unsigned MAX_DIM       = 5,
  parameter int unsigned SLOTS_PER_DIM = 2,
  parameter int unsigned ELEM_WIDTH    = 8,
  parameter int unsigned DIM_BITS      = 3,
  parameter int unsigned SLOT_BITS     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_start,
  input  logic [3:0]               wr_m,
  input  logic [3:0]               wr_n,
  input  logic [ELEM_WIDTH-1:0]    elem_in,
  input  logic                     elem_valid,
  input  logic                     wr_finish,
  output logic                     wr_busy,
  output logic                     wr_done,
  output logic                     wr_err,
  output logic [SLOT_BITS-1:0]     wr_slot,
  input  logic                     rd_en,
  input  logic [3:0]               rd_m,
  input  logic [3:0]               rd_n,
  input  logic [SLOT_BITS-1:0]     rd_slot,
  input  logic [DIM_BITS-1:0]      rd_row,
  input  logic [DIM_BITS-1:0]      rd_col,
  output logic [ELEM_WIDTH-1:0]    rd_data,
  output logic                     rd_valid,
  output logic                     rd_hit,
  input  logic [3:0]               q_m,
  input  logic [3:0]               q_n,
  output logic [SLOT_BITS:0]       q_count,
  output logic [SLOTS_PER_DIM-1:0] q_valid_mask,
  input  logic                     clr_en,
  input  logic [3:0]               clr_m,
  input  logic [3:0]               clr_n
);

  localparam int unsigned AREA       = MAX_DIM * MAX_DIM;
  localparam int unsigned NUM_GSLOTS = AREA * SLOTS_PER_DIM;
  localparam int unsigned MEM_DEPTH  = NUM_GSLOTS * AREA;
  localparam int unsigned PAIR_W     = (AREA > 1) ? $clog2(AREA) : 1;
  localparam int unsigned GSLOT_W    = (NUM_GSLOTS > 1) ? $clog2(NUM_GSLOTS) : 1;
  localparam int unsigned MEM_AW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned CNT_W      = SLOT_BITS + 1;
  localparam logic [3:0]  MAX_DIM4   = 4'(MAX_DIM);

  typedef enum logic [1:0] {IDLE, WRITE, PAD} state_t;

  function automatic logic dims_ok(input logic [3:0] m, input logic [3:0] n);
    return (m != 4'd0) && (n != 4'd0) && (m <= MAX_DIM4) && (n <= MAX_DIM4);
  endfunction

  function automatic logic [PAIR_W-1:0] pair_of(input logic [3:0] m, input logic [3:0] n);
    return PAIR_W'((32'(m) - 32'd1) * MAX_DIM + 32'(n) - 32'd1);
  endfunction

  function automatic logic [GSLOT_W-1:0] gslot_of(input logic [PAIR_W-1:0] p,
                                                  input logic [SLOT_BITS-1:0] s);
    return GSLOT_W'(32'(p) * SLOTS_PER_DIM + 32'(s));
  endfunction

  logic [ELEM_WIDTH-1:0] mem [MEM_DEPTH];
  logic [NUM_GSLOTS-1:0] valid;
  logic [SLOT_BITS-1:0]  ptr [AREA];

  state_t               state;
  logic [3:0]           m_r, n_r;
  logic [DIM_BITS-1:0]  row_r, col_r;
  logic [SLOT_BITS-1:0] slot_r;
  logic [PAIR_W-1:0]    pair_r;
  logic [GSLOT_W-1:0]   gslot_r;

  logic [PAIR_W-1:0]    start_pair, clr_pair, rd_pair, q_pair;
  logic [GSLOT_W-1:0]   rd_gslot;
  logic [SLOT_BITS-1:0] start_slot, ptr_next;
  logic                 at_last, col_last, commit, mem_we, rd_hit_c;
  logic [MEM_AW-1:0]    wr_addr, rd_addr;
  logic [ELEM_WIDTH-1:0] mem_wdata;

  // Address decode, stream position and commit detection
  always_comb begin
    start_pair = pair_of(wr_m, wr_n);
    clr_pair   = pair_of(clr_m, clr_n);
    rd_pair    = pair_of(rd_m, rd_n);
    q_pair     = pair_of(q_m, q_n);
    start_slot = ptr[start_pair];
    rd_gslot   = gslot_of(rd_pair, rd_slot);
    col_last   = (32'(col_r) + 32'd1) == 32'(n_r);
    at_last    = col_last && ((32'(row_r) + 32'd1) == 32'(m_r));
    ptr_next   = ((32'(slot_r) + 32'd1) >= SLOTS_PER_DIM) ? '0 : slot_r + 1'b1;
    commit     = ((state == WRITE) && elem_valid && at_last) || ((state == PAD) && at_last);
    mem_we     = ((state == WRITE) && elem_valid) || (state == PAD);
    mem_wdata  = (state == PAD) ? '0 : elem_in;
    wr_addr    = MEM_AW'(32'(gslot_r) * AREA + 32'(row_r) * MAX_DIM + 32'(col_r));
    rd_addr    = MEM_AW'(32'(rd_gslot) * AREA + 32'(rd_row) * MAX_DIM + 32'(rd_col));
    rd_hit_c   = dims_ok(rd_m, rd_n) && (32'(rd_slot) < SLOTS_PER_DIM) && valid[rd_gslot] &&
                 (32'(rd_row) < 32'(rd_m)) && (32'(rd_col) < 32'(rd_n));
  end

  // Per-pair occupancy query
  always_comb begin
    q_valid_mask = '0;
    q_count      = '0;
    if (dims_ok(q_m, q_n)) begin
      for (int s = 0; s < SLOTS_PER_DIM; s++) begin
        q_valid_mask[s] = valid[gslot_of(q_pair, SLOT_BITS'(s))];
      end
    end
    for (int s = 0; s < SLOTS_PER_DIM; s++) begin
      q_count = q_count + CNT_W'(q_valid_mask[s]);
    end
  end

  // Element storage; deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= mem_wdata;
  end

  // Write FSM with valid-bit and round-robin pointer bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wr_busy <= 1'b0;
      wr_done <= 1'b0;
      wr_err  <= 1'b0;
      wr_slot <= '0;
      valid   <= '0;
      for (int p = 0; p < AREA; p++) ptr[p] <= '0;
      m_r     <= '0;
      n_r     <= '0;
      row_r   <= '0;
      col_r   <= '0;
      slot_r  <= '0;
      pair_r  <= '0;
      gslot_r <= '0;
    end else begin
      wr_done <= 1'b0;
      wr_err  <= 1'b0;

      // Clear comes first so a same-cycle commit keeps its own slot
      if (clr_en && dims_ok(clr_m, clr_n)) begin
        for (int s = 0; s < SLOTS_PER_DIM; s++) valid[gslot_of(clr_pair, SLOT_BITS'(s))] <= 1'b0;
        ptr[clr_pair] <= '0;
      end

      case (state)
        IDLE: begin
          if (wr_start) begin
            if (dims_ok(wr_m, wr_n)) begin
              m_r     <= wr_m;
              n_r     <= wr_n;
              row_r   <= '0;
              col_r   <= '0;
              slot_r  <= start_slot;
              pair_r  <= start_pair;
              gslot_r <= gslot_of(start_pair, start_slot);
              valid[gslot_of(start_pair, start_slot)] <= 1'b0;
              wr_busy <= 1'b1;
              state   <= WRITE;
            end else begin
              wr_err <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (!commit) begin
            if (elem_valid) begin
              if (col_last) begin
                col_r <= '0;
                row_r <= row_r + 1'b1;
              end else begin
                col_r <= col_r + 1'b1;
              end
            end
            if (wr_finish) begin
`ifdef MATRIX_BANK_AUTOPAD_EN
              state <= PAD;
`else
              wr_err  <= 1'b1;
              wr_busy <= 1'b0;
              state   <= IDLE;
`endif
            end
          end
        end
        PAD: begin
          if (!commit) begin
            if (col_last) begin
              col_r <= '0;
              row_r <= row_r + 1'b1;
            end else begin
              col_r <= col_r + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (commit) begin
        valid[gslot_r] <= 1'b1;
        ptr[pair_r]    <= ptr_next;
        wr_done        <= 1'b1;
        wr_slot        <= slot_r;
        wr_busy        <= 1'b0;
        state          <= IDLE;
      end
    end
  end

  // Registered single-element read port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_hit   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_hit  <= rd_hit_c;
        rd_data <= rd_hit_c ? mem[rd_addr] : '0;
      end else begin
        rd_hit <= 1'b0;
      end
    end
  end

endmodule
